// File: rtl/z80_ram_arbiter.sv
// z80_ram_arbiter: shares one external SRAM between the Z80 (post-MMU address)
// and a single DMA requester. Every access is a fixed ACC_CYC-clock strobe cycle.
// The Z80 is stalled through nWAIT while its access is pending. A starvation
// counter forces the DMA through after STARVE_LIM consecutive contested CPU grants.
module z80_ram_arbiter #(
    parameter int AW         = 20,
    parameter int ACC_CYC    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          nMREQ,
    input  logic          nRD,
    input  logic          nWR,
    input  logic          pt_hit,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          nWAIT,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic          dma_ack,
    output logic [7:0]    dma_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_wdata,
    input  logic [7:0]    sram_rdata,
    output logic          sram_nCE,
    output logic          sram_nOE,
    output logic          sram_nWE
);

    localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cyc;
    logic [SW-1:0]   r_starve;
    logic [AW-1:0]   r_sram_addr;
    logic [7:0]      r_sram_wdata;
    logic            r_we;
    logic            r_cpu_done;
    logic [7:0]      r_cpu_rdata;
    logic            r_dma_ack;
    logic [7:0]      r_dma_rdata;

    logic            w_cpu_pend;
    logic            w_dma_pend;
    logic            w_cpu_win;
    logic            w_dma_win;
    logic            w_last;
    logic            w_acc;

    // A CPU access finished while nMREQ stays low must not be re-issued;
    // nRD and nWR both low still counts as a request (handled as a write).
    assign w_cpu_pend = ~nMREQ & (~nRD | ~nWR) & ~pt_hit & ~r_cpu_done;
    // The requester only sees dma_ack one clock later, so ignore its still-high
    // request in the ack cycle to avoid a spurious second access.
    assign w_dma_pend = dma_req & ~r_dma_ack;
    assign w_last     = (r_cyc == CW'(ACC_CYC - 1));
    assign w_acc      = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state: arbitration happens only in IDLE; accesses run to their last cycle
    always_comb begin
        w_next    = r_state;
        w_cpu_win = 1'b0;
        w_dma_win = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_pend && !(w_dma_pend && r_starve >= SW'(STARVE_LIM))) begin
                    w_cpu_win = 1'b1;
                    w_next    = S_CPU;
                end else if (w_dma_pend) begin
                    w_dma_win = 1'b1;
                    w_next    = S_DMA;
                end
            end
            S_CPU, S_DMA: if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: strobes decode from state so a reset drops them immediately
    always_comb begin
        nWAIT    = ~w_cpu_pend;
        sram_nCE = ~w_acc;
        sram_nOE = ~(w_acc & ~r_we);
        // Write strobe releases in the last cycle so data is held past nWE rise
        sram_nWE = ~(w_acc & r_we & ~w_last);
    end

    // Access datapath: grant capture, cycle count, starvation, completion
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_cyc        <= '0;
            r_starve     <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_we         <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_ack    <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_cyc     <= (w_acc && !w_last) ? r_cyc + CW'(1) : '0;
            r_dma_ack <= (r_state == S_DMA) && w_last;

            if (w_cpu_win) begin
                r_sram_addr  <= cpu_addr;
                r_sram_wdata <= cpu_wdata;
                r_we         <= ~nWR;
            end else if (w_dma_win) begin
                r_sram_addr  <= dma_addr;
                r_sram_wdata <= dma_wdata;
                r_we         <= dma_we;
            end

            if (r_state == S_IDLE) begin
                if (!w_dma_pend || w_dma_win) r_starve <= '0;
                else if (w_cpu_win)           r_starve <= r_starve + SW'(1);
            end

            // A CPU that dropped nMREQ mid-access gets no data and no done flag
            if (nMREQ)                                  r_cpu_done <= 1'b0;
            else if ((r_state == S_CPU) && w_last)      r_cpu_done <= 1'b1;

            if ((r_state == S_CPU) && w_last && !nMREQ && !r_we) r_cpu_rdata <= sram_rdata;
            if ((r_state == S_DMA) && w_last && !r_we)           r_dma_rdata <= sram_rdata;
        end
    end

    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign cpu_rdata  = r_cpu_rdata;
    assign dma_ack    = r_dma_ack;
    assign dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_z80_ram_arbiter.sv
// Bench for z80_ram_arbiter: per-clock directed vector table plus hand-written
// sequences for starvation, mid-access nMREQ withdrawal and reset mid-access.
module tb_z80_ram_arbiter;

    logic        clk = 1'b0;
    logic        nRESET, nMREQ, nRD, nWR, pt_hit;
    logic [19:0] cpu_addr, dma_addr, sram_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, sram_wdata, sram_rdata;
    logic        nWAIT, dma_req, dma_we, dma_ack, sram_nCE, sram_nOE, sram_nWE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    z80_ram_arbiter #(.AW(20), .ACC_CYC(2), .STARVE_LIM(4)) dut (
        .clk(clk), .nRESET(nRESET), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR), .pt_hit(pt_hit),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .nWAIT(nWAIT),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_nCE(sram_nCE), .sram_nOE(sram_nOE), .sram_nWE(sram_nWE)
    );

    typedef struct {
        logic nm, nrd, nwr, pt;
        logic [19:0] caddr;
        logic [7:0]  cwd;
        logic dq, dwe;
        logic [19:0] daddr;
        logic [7:0]  dwd, srd;
        logic wt, ce, oe, we;
        logic [19:0] saddr;
        logic [7:0]  swd, crd;
        logic ak;
        logic [7:0]  drd;
    } vec_t;

    vec_t tbl[31];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        nMREQ = 1; nRD = 1; nWR = 1; pt_hit = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; sram_rdata = 0;
    endtask

    initial begin
        // inputs: nm nrd nwr pt caddr cwd dq dwe daddr dwd srd | expected: nWAIT nCE nOE nWE saddr swd crd ack drd
        // CPU read 0x12345 alone
        tbl[0]  = '{0,0,1,0,20'h12345,8'h00,0,0,20'h0,8'h00,8'hA5, 0,1,1,1,20'h00000,8'h00,8'h00,0,8'h00};
        tbl[1]  = '{0,0,1,0,20'h12345,8'h00,0,0,20'h0,8'h00,8'hA5, 0,0,0,1,20'h12345,8'h00,8'h00,0,8'h00};
        tbl[2]  = '{0,0,1,0,20'h12345,8'h00,0,0,20'h0,8'h00,8'hA5, 0,0,0,1,20'h12345,8'h00,8'h00,0,8'h00};
        tbl[3]  = '{0,0,1,0,20'h12345,8'h00,0,0,20'h0,8'h00,8'hA5, 1,1,1,1,20'h12345,8'h00,8'hA5,0,8'h00};
        tbl[4]  = '{1,1,1,0,20'h12345,8'h00,0,0,20'h0,8'h00,8'hA5, 1,1,1,1,20'h12345,8'h00,8'hA5,0,8'h00};
        // CPU write 0x0ACFF data 0x7F
        tbl[5]  = '{0,1,0,0,20'h0ACFF,8'h7F,0,0,20'h0,8'h00,8'hA5, 0,1,1,1,20'h12345,8'h00,8'hA5,0,8'h00};
        tbl[6]  = '{0,1,0,0,20'h0ACFF,8'h7F,0,0,20'h0,8'h00,8'hA5, 0,0,1,0,20'h0ACFF,8'h7F,8'hA5,0,8'h00};
        tbl[7]  = '{0,1,0,0,20'h0ACFF,8'h7F,0,0,20'h0,8'h00,8'hA5, 0,0,1,1,20'h0ACFF,8'h7F,8'hA5,0,8'h00};
        tbl[8]  = '{0,1,0,0,20'h0ACFF,8'h7F,0,0,20'h0,8'h00,8'hA5, 1,1,1,1,20'h0ACFF,8'h7F,8'hA5,0,8'h00};
        tbl[9]  = '{1,1,1,0,20'h0ACFF,8'h7F,0,0,20'h0,8'h00,8'hA5, 1,1,1,1,20'h0ACFF,8'h7F,8'hA5,0,8'h00};
        // page-table hit write: no SRAM strobe, no wait
        tbl[10] = '{0,1,0,1,20'h00100,8'h55,0,0,20'h0,8'h00,8'hA5, 1,1,1,1,20'h0ACFF,8'h7F,8'hA5,0,8'h00};
        tbl[11] = '{0,1,0,1,20'h00100,8'h55,0,0,20'h0,8'h00,8'hA5, 1,1,1,1,20'h0ACFF,8'h7F,8'hA5,0,8'h00};
        tbl[12] = '{1,1,1,0,20'h00100,8'h55,0,0,20'h0,8'h00,8'hA5, 1,1,1,1,20'h0ACFF,8'h7F,8'hA5,0,8'h00};
        // DMA read 0x00010 alone, CPU read arrives during it and waits
        tbl[13] = '{1,1,1,0,20'h00100,8'h55,1,0,20'h00010,8'h00,8'h3C, 1,1,1,1,20'h0ACFF,8'h7F,8'hA5,0,8'h00};
        tbl[14] = '{0,0,1,0,20'h00200,8'h00,1,0,20'h00010,8'h00,8'h3C, 0,0,0,1,20'h00010,8'h00,8'hA5,0,8'h00};
        tbl[15] = '{0,0,1,0,20'h00200,8'h00,1,0,20'h00010,8'h00,8'h3C, 0,0,0,1,20'h00010,8'h00,8'hA5,0,8'h00};
        tbl[16] = '{0,0,1,0,20'h00200,8'h00,1,0,20'h00010,8'h00,8'h3C, 0,1,1,1,20'h00010,8'h00,8'hA5,1,8'h3C};
        tbl[17] = '{0,0,1,0,20'h00200,8'h00,0,0,20'h00010,8'h00,8'h96, 0,0,0,1,20'h00200,8'h00,8'hA5,0,8'h3C};
        tbl[18] = '{0,0,1,0,20'h00200,8'h00,0,0,20'h00010,8'h00,8'h96, 0,0,0,1,20'h00200,8'h00,8'hA5,0,8'h3C};
        tbl[19] = '{0,0,1,0,20'h00200,8'h00,0,0,20'h00010,8'h00,8'h96, 1,1,1,1,20'h00200,8'h00,8'h96,0,8'h3C};
        tbl[20] = '{1,1,1,0,20'h00200,8'h00,0,0,20'h00010,8'h00,8'h96, 1,1,1,1,20'h00200,8'h00,8'h96,0,8'h3C};
        // nRD and nWR both low: handled as a write
        tbl[21] = '{0,0,0,0,20'h00333,8'hC3,0,0,20'h00010,8'h00,8'h96, 0,1,1,1,20'h00200,8'h00,8'h96,0,8'h3C};
        tbl[22] = '{0,0,0,0,20'h00333,8'hC3,0,0,20'h00010,8'h00,8'h96, 0,0,1,0,20'h00333,8'hC3,8'h96,0,8'h3C};
        tbl[23] = '{0,0,0,0,20'h00333,8'hC3,0,0,20'h00010,8'h00,8'h96, 0,0,1,1,20'h00333,8'hC3,8'h96,0,8'h3C};
        tbl[24] = '{0,0,0,0,20'h00333,8'hC3,0,0,20'h00010,8'h00,8'h96, 1,1,1,1,20'h00333,8'hC3,8'h96,0,8'h3C};
        tbl[25] = '{1,1,1,0,20'h00333,8'hC3,0,0,20'h00010,8'h00,8'h96, 1,1,1,1,20'h00333,8'hC3,8'h96,0,8'h3C};
        // DMA write 0x00444, request dropped before ack: access completes, ack still pulses
        tbl[26] = '{1,1,1,0,20'h00333,8'hC3,1,1,20'h00444,8'h5A,8'h3C, 1,1,1,1,20'h00333,8'hC3,8'h96,0,8'h3C};
        tbl[27] = '{1,1,1,0,20'h00333,8'hC3,0,1,20'h00444,8'h5A,8'h3C, 1,0,1,0,20'h00444,8'h5A,8'h96,0,8'h3C};
        tbl[28] = '{1,1,1,0,20'h00333,8'hC3,0,1,20'h00444,8'h5A,8'h3C, 1,0,1,1,20'h00444,8'h5A,8'h96,0,8'h3C};
        tbl[29] = '{1,1,1,0,20'h00333,8'hC3,0,1,20'h00444,8'h5A,8'h3C, 1,1,1,1,20'h00444,8'h5A,8'h96,1,8'h3C};
        tbl[30] = '{1,1,1,0,20'h00333,8'hC3,0,1,20'h00444,8'h5A,8'h3C, 1,1,1,1,20'h00444,8'h5A,8'h96,0,8'h3C};

        // Reset
        idle_inputs();
        nRESET = 1;
        #2 nRESET = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst nCE", sram_nCE, 1); chk("rst nOE", sram_nOE, 1); chk("rst nWE", sram_nWE, 1);
        chk("rst sram_addr", sram_addr, 0); chk("rst sram_wdata", sram_wdata, 0);
        chk("rst nWAIT", nWAIT, 1); chk("rst dma_ack", dma_ack, 0);
        chk("rst cpu_rdata", cpu_rdata, 0); chk("rst dma_rdata", dma_rdata, 0);
        nRESET = 1;

        // Table: drive at the falling edge, compare just after
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            nMREQ = tbl[i].nm; nRD = tbl[i].nrd; nWR = tbl[i].nwr; pt_hit = tbl[i].pt;
            cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            dma_req = tbl[i].dq; dma_we = tbl[i].dwe; dma_addr = tbl[i].daddr;
            dma_wdata = tbl[i].dwd; sram_rdata = tbl[i].srd;
            #1;
            chk($sformatf("row%0d nWAIT", i), nWAIT, tbl[i].wt);
            chk($sformatf("row%0d nCE", i), sram_nCE, tbl[i].ce);
            chk($sformatf("row%0d nOE", i), sram_nOE, tbl[i].oe);
            chk($sformatf("row%0d nWE", i), sram_nWE, tbl[i].we);
            chk($sformatf("row%0d sram_addr", i), sram_addr, tbl[i].saddr);
            chk($sformatf("row%0d sram_wdata", i), sram_wdata, tbl[i].swd);
            chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, tbl[i].crd);
            chk($sformatf("row%0d dma_ack", i), dma_ack, tbl[i].ak);
            chk($sformatf("row%0d dma_rdata", i), dma_rdata, tbl[i].drd);
        end

        // Starvation: DMA held high, CPU re-requests at every idle slot
        // (withdrawing nMREQ in the last access cycle so no data is taken)
        @(negedge clk);
        idle_inputs();
        dma_req = 1; dma_addr = 20'h00555; sram_rdata = 8'h11; nRD = 0;
        for (int k = 0; k < 4; k++) begin
            nMREQ = 0; cpu_addr = 20'h01000 + 20'(k);
            @(negedge clk); #1;
            chk($sformatf("starve grant%0d addr", k), sram_addr, 20'h01000 + 20'(k));
            chk($sformatf("starve grant%0d nOE", k), sram_nOE, 0);
            @(negedge clk);
            nMREQ = 1;
            @(negedge clk);
        end
        nMREQ = 0; cpu_addr = 20'h01004;
        @(negedge clk); #1;
        chk("starve dma addr", sram_addr, 20'h00555);
        chk("starve cpu stalled", nWAIT, 0);
        chk("starve dma nOE", sram_nOE, 0);
        nMREQ = 1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("starve dma_ack", dma_ack, 1);
        chk("starve dma_rdata", dma_rdata, 8'h11);
        chk("aborted cpu_rdata kept", cpu_rdata, 8'h96);
        dma_req = 0;
        @(negedge clk); #1;
        chk("starve ack one clk", dma_ack, 0);
        // Counter was cleared by the forced DMA grant: contested slot goes to CPU
        dma_req = 1; nMREQ = 0; cpu_addr = 20'h01100; sram_rdata = 8'h22;
        @(negedge clk); #1;
        chk("post-starve cpu wins", sram_addr, 20'h01100);
        @(negedge clk);
        @(negedge clk); #1;
        chk("post-starve cpu_rdata", cpu_rdata, 8'h22);
        chk("post-starve nWAIT", nWAIT, 1);
        nMREQ = 1; dma_req = 0;
        @(negedge clk);

        // Reset in the middle of a DMA write
        dma_req = 1; dma_we = 1; dma_addr = 20'h00666; dma_wdata = 8'h77;
        @(negedge clk); #1;
        chk("rstmid nCE before", sram_nCE, 0);
        chk("rstmid nWE before", sram_nWE, 0);
        #2 nRESET = 0;
        #1;
        chk("rstmid nCE async", sram_nCE, 1);
        chk("rstmid nWE async", sram_nWE, 1);
        chk("rstmid sram_addr", sram_addr, 0);
        @(negedge clk); #1;
        chk("rstmid no ack", dma_ack, 0);
        nRESET = 1; dma_req = 0;
        @(negedge clk); #1;
        chk("rstmid ack after release", dma_ack, 0);
        chk("rstmid idle nCE", sram_nCE, 1);
        nMREQ = 0; nRD = 0; cpu_addr = 20'h00777; sram_rdata = 8'h33;
        @(negedge clk); #1;
        chk("after reset cpu nOE", sram_nOE, 0);
        chk("after reset cpu addr", sram_addr, 20'h00777);
        @(negedge clk);
        @(negedge clk); #1;
        chk("after reset cpu_rdata", cpu_rdata, 8'h33);
        nMREQ = 1; nRD = 1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
